// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions: per-bit command encoding and the excitation
// function that maps a (current, next) bit pair onto a J/K command.
package jk_pkg;

  // Encoded as {J, K} so a command can drive a JK cell directly.
  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_cmd_t;

  // Minimal excitation for one bit: only drive J or K when the bit must move.
  // Toggle is never produced, so J and K are never high together.
  function automatic jk_cmd_t jk_excite(input logic q, input logic n);
    jk_cmd_t cmd;
    case ({q, n})
      2'b01:   cmd = JK_SET;
      2'b10:   cmd = JK_RESET;
      default: cmd = JK_HOLD;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-high reset to 0.
module jk_cell
  import jk_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic    q_q;
  jk_cmd_t cmd;

  assign cmd = jk_cmd_t'({j_i, k_i});
  assign q_o = q_q;

  // JK truth table: hold, reset, set, toggle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= 1'b0;
    end else begin
      case (cmd)
        JK_HOLD:   q_q <= q_q;
        JK_RESET:  q_q <= 1'b0;
        JK_SET:    q_q <= 1'b1;
        JK_TOGGLE: q_q <= ~q_q;
        default:   q_q <= q_q;
      endcase
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter with parallel load, built from one JK cell per
// state bit. The desired next count is computed arithmetically and converted
// to J/K excitation per bit; terminal count is combinational and the wrap
// indication is a registered one-cycle pulse.
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             up_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             wrap_o
);

  // Reject moduli the counter cannot represent.
  if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_bad_mod
    $error("jk_mod_counter: MOD must lie in 2..2**WIDTH");
  end

  // One extra bit so that MOD == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MOD);
  localparam logic [WIDTH:0]   LAST_W = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH-1:0] LAST_N = LAST_W[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH:0]   q_ext;
  logic [WIDTH:0]   d_ext;
  logic             wrap_q;
  logic             wrap_d;
  logic [WIDTH-1:0] j_w;
  logic [WIDTH-1:0] k_w;

  assign q_ext = {1'b0, count_q};
  assign d_ext = {1'b0, d_i};

  // Next count and wrap event: load beats count beats hold; loads never wrap.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (ld_i) begin
      count_d = (d_ext >= MOD_W) ? LAST_N : d_i;
    end else if (en_i) begin
      if (up_i) begin
        if (q_ext == LAST_W) begin
          count_d = '0;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q + ONE;
        end
      end else begin
        if (q_ext == '0) begin
          count_d = LAST_N;
          wrap_d  = 1'b1;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  // One JK cell per state bit, excited from the (current, next) bit pair.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    jk_cmd_t cmd;
    assign cmd     = jk_excite(count_q[gi], count_d[gi]);
    assign j_w[gi] = cmd[1];
    assign k_w[gi] = cmd[0];

    jk_cell u_cell (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .j_i   (j_w[gi]),
      .k_i   (k_w[gi]),
      .q_o   (count_q[gi])
    );
  end

  // Wrap pulse: set on a counting wrap edge, cleared on the following edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign q_o    = count_q;
  assign wrap_o = wrap_q;
  assign tc_o   = en_i & (up_i ? (q_ext == LAST_W) : (q_ext == '0));

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter: a 4-bit/mod-10 and a 3-bit/mod-8 instance share
// the same stimulus and are compared against a modular-arithmetic model.
module tb_jk_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       up  = 1'b1;
  logic       ld  = 1'b0;
  logic [3:0] d   = '0;

  logic [3:0] q_a;
  logic       tc_a, wrap_a;
  logic [2:0] q_b;
  logic       tc_b, wrap_b;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state, one entry per instance.
  int mods [2] = '{10, 8};
  int m_q  [2];
  int m_w  [2];

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(4), .MOD(10)) dut (
    .clk_i (clk), .rst_i (rst), .en_i (en), .up_i (up), .ld_i (ld),
    .d_i   (d),   .q_o   (q_a), .tc_o (tc_a), .wrap_o (wrap_a)
  );

  jk_mod_counter #(.WIDTH(3), .MOD(8)) dut8 (
    .clk_i (clk), .rst_i (rst), .en_i (en), .up_i (up), .ld_i (ld),
    .d_i   (d[2:0]), .q_o (q_b), .tc_o (tc_b), .wrap_o (wrap_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_q[k] = 0;
      m_w[k] = 0;
    end
  endtask

  task automatic model_edge();
    int dv;
    for (int k = 0; k < 2; k++) begin
      dv = (k == 0) ? int'(d) : int'(d[2:0]);
      m_w[k] = 0;
      if (ld) begin
        m_q[k] = (dv >= mods[k]) ? mods[k] - 1 : dv;
      end else if (en) begin
        if (up) begin
          m_w[k] = (m_q[k] == mods[k] - 1) ? 1 : 0;
          m_q[k] = (m_q[k] + 1) % mods[k];
        end else begin
          m_w[k] = (m_q[k] == 0) ? 1 : 0;
          m_q[k] = (m_q[k] + mods[k] - 1) % mods[k];
        end
      end
    end
  endtask

  function automatic logic exp_tc(input int k);
    return en & (up ? (m_q[k] == mods[k] - 1) : (m_q[k] == 0));
  endfunction

  // One clock: drive after negedge, check TC and J/K before the edge, then
  // check Q and WRAP just after the edge. Ends on the following negedge.
  task automatic step(input logic en_v, input logic up_v, input logic ld_v, input logic [3:0] d_v);
    en = en_v; up = up_v; ld = ld_v; d = d_v;
    #1;
    chk("tc_a", 32'(tc_a), 32'(exp_tc(0)));
    chk("tc_b", 32'(tc_b), 32'(exp_tc(1)));
    chk("jk_a", 32'(dut.j_w & dut.k_w), 32'd0);
    chk("jk_b", 32'(dut8.j_w & dut8.k_w), 32'd0);
    @(posedge clk);
    model_edge();
    #1;
    chk("q_a", 32'(q_a), 32'(m_q[0]));
    chk("wrap_a", 32'(wrap_a), 32'(m_w[0]));
    chk("q_b", 32'(q_b), 32'(m_q[1]));
    chk("wrap_b", 32'(wrap_b), 32'(m_w[1]));
    $display("step en=%0b up=%0b ld=%0b d=%0d -> q_a=%0d wrap_a=%0b q_b=%0d wrap_b=%0b",
             en_v, up_v, ld_v, d_v, q_a, wrap_a, q_b, wrap_b);
    @(negedge clk);
  endtask

  // Reset raised mid-cycle: outputs must clear before the next edge and stay
  // cleared across edges while reset is held, even with EN high.
  task automatic mid_reset();
    en = 1'b1; up = 1'b1; ld = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_async_q", 32'(q_a), 32'd0);
    chk("rst_async_wrap", 32'(wrap_a), 32'd0);
    chk("rst_async_q_b", 32'(q_b), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_q", 32'(q_a), 32'd0);
      chk("rst_hold_wrap", 32'(wrap_a), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    $display("mid-cycle reset -> q_a=%0d wrap_a=%0b", q_a, wrap_a);
  endtask

  initial begin
    model_reset();
    // Reset state while RST is held from time zero.
    #2;
    chk("reset_q", 32'(q_a), 32'd0);
    chk("reset_wrap", 32'(wrap_a), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Up count 12 cycles: 1..9,0,1,2 (mod 10); 1..7,0,... (mod 8).
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 4'd0);

    // Reset mid-count at Q=5.
    step(1'b0, 1'b1, 1'b1, 4'd5);
    chk("q_before_rst", 32'(q_a), 32'd5);
    mid_reset();

    // Reset with a wrap pulse pending.
    step(1'b0, 1'b1, 1'b1, 4'd9);
    step(1'b1, 1'b1, 1'b0, 4'd0);
    chk("wrap_pending", 32'(wrap_a), 32'd1);
    mid_reset();

    // Down count from reset: 9,8,...
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, 4'd0);

    // Loads: in range, clamped, and load-beats-count at the wrap point.
    step(1'b0, 1'b1, 1'b1, 4'd7);
    step(1'b0, 1'b1, 1'b1, 4'd13);
    chk("clamp_q", 32'(q_a), 32'd9);
    step(1'b1, 1'b1, 1'b1, 4'd0);
    chk("load_no_wrap", 32'(wrap_a), 32'd0);

    // Hold at 4, then alternate direction every cycle.
    step(1'b0, 1'b1, 1'b1, 4'd4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 4; i++) step(1'b1, (i % 2 == 0) ? 1'b1 : 1'b0, 1'b0, 4'd0);
    chk("dir_toggle_q", 32'(q_a), 32'd4);

    // Random traffic with occasional mid-cycle resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        mid_reset();
      end else begin
        step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
             4'($urandom_range(0, 15)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
